ld_st_rg_serial_tx: RTL and testbench

Transmit-side partner of the 4-bit load/store register. It captures a parallel word on a load strobe and shifts it out serially, LSB first, on a single line. A ready/busy/done handshake lets a controller pace successive words. It sits between the load/store register bank and any bit-serial consumer or link.

---
 rtl/ld_st_rg_serial_tx_if.sv | 48 ++++
 rtl/ld_st_rg_serial_tx.sv | 160 ++++++++++++++++
 tb/tb_ld_st_rg_serial_tx.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ld_st_rg_serial_tx_if.sv
// ---------------------------------------------------------------------------
// ld_st_rg_serial_tx_if
// Handshake/data bundle between a controller and the serial transmitter.
//
// Signals:
//   sl_in   parallel word to transmit (controller -> transmitter)
//   l_s     load strobe, honoured only while ready=1
//   hold    pause request, freezes a word in flight
//   sl_ser  serial data line, idles at 1
//   ready   transmitter idle and able to accept l_s
//   busy    word in flight (data bits or parity bit on the line)
//   done    one-cycle pulse after the last bit has been driven
//
// Modports:
//   master  controller side (drives sl_in, l_s, hold)
//   slave   transmitter side (drives sl_ser, ready, busy, done)
// ---------------------------------------------------------------------------
interface ld_st_rg_serial_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] sl_in;
    logic             l_s;
    logic             hold;
    logic             sl_ser;
    logic             ready;
    logic             busy;
    logic             done;

    modport master (
        output sl_in,
        output l_s,
        output hold,
        input  sl_ser,
        input  ready,
        input  busy,
        input  done
    );

    modport slave (
        input  sl_in,
        input  l_s,
        input  hold,
        output sl_ser,
        output ready,
        output busy,
        output done
    );
endinterface

// File: rtl/ld_st_rg_serial_tx.sv
// ---------------------------------------------------------------------------
// ld_st_rg_serial_tx
// Transmit-side partner of the load/store register. Captures a parallel word
// on a load strobe and shifts it out LSB first on a single serial line, with
// a ready/busy/done handshake so a controller can pace successive words.
//
// Parameters:
//   WIDTH  data word width in bits (>= 2)
//   CNT_W  bit-counter width, 2**CNT_W must be >= WIDTH
//
// Ports:
//   clk  system clock, rising-edge active
//   clr  synchronous active-high reset, overrides everything (a word in
//        flight is dropped without a done pulse)
//   bus  slave side of ld_st_rg_serial_tx_if (sl_in, l_s, hold in;
//        sl_ser, ready, busy, done out)
//
// Optional feature:
//   LD_ST_RG_PARITY_EN  when defined, an even-parity bit (XOR of the captured
//                       word) is sent in a PAR state after the last data bit.
// ---------------------------------------------------------------------------
module ld_st_rg_serial_tx #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 2
) (
    input  logic                  clk,
    input  logic                  clr,
    ld_st_rg_serial_tx_if.slave   bus
);

`ifdef LD_ST_RG_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        PAR   = 2'd3
    } state_t;
`else
    // Encoding 2'd3 is unused here and falls back to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
`endif

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   sreg_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               last_bit;

    logic               sl_ser_c;
    logic               ready_c;
    logic               busy_c;
    logic               done_c;

`ifdef LD_ST_RG_PARITY_EN
    // Parity is taken from the word at capture time because the shift
    // register no longer holds the whole word once shifting starts.
    logic               par_q;
`endif

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: capture on load, shift while not held. The counter stops at
    // the last bit instead of incrementing past it, so it can never wrap
    // inside a word even when 2**CNT_W == WIDTH.
    always_ff @(posedge clk) begin
        if (clr) begin
            sreg_q <= '0;
            cnt_q  <= '0;
`ifdef LD_ST_RG_PARITY_EN
            par_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.l_s) begin
                        sreg_q <= bus.sl_in;
                        cnt_q  <= '0;
`ifdef LD_ST_RG_PARITY_EN
                        par_q  <= ^bus.sl_in;
`endif
                    end
                end
                SHIFT: begin
                    if (!bus.hold) begin
                        sreg_q <= sreg_q >> 1;
                        if (!last_bit) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and output decode. Outputs depend only on the registered
    // state and shift register, so they are glitch-free relative to inputs.
    always_comb begin
        state_d  = state_q;
        sl_ser_c = 1'b1;
        ready_c  = 1'b0;
        busy_c   = 1'b0;
        done_c   = 1'b0;
        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.l_s) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy_c   = 1'b1;
                sl_ser_c = sreg_q[0];
                if (!bus.hold && last_bit) begin
`ifdef LD_ST_RG_PARITY_EN
                    state_d = PAR;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef LD_ST_RG_PARITY_EN
            PAR: begin
                busy_c   = 1'b1;
                sl_ser_c = par_q;
                if (!bus.hold) begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.sl_ser = sl_ser_c;
    assign bus.ready  = ready_c;
    assign bus.busy   = busy_c;
    assign bus.done   = done_c;

endmodule

// File: tb/tb_ld_st_rg_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_ld_st_rg_serial_tx
// Self-checking bench for ld_st_rg_serial_tx (WIDTH=4). A reference model
// keeps the remaining frame of the word in flight as a queue of line symbols
// {sl_ser, ready, busy, done}; the front symbol is what the line must show,
// an empty queue means idle. Directed scenarios are followed by random
// traffic, and every cycle is compared against the model.
// Honours LD_ST_RG_PARITY_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_ld_st_rg_serial_tx;

    localparam int WIDTH = 4;
`ifdef LD_ST_RG_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    localparam logic [3:0] SYM_IDLE = 4'b1100;
    localparam logic [3:0] SYM_DONE = 4'b1001;

    logic clk = 1'b0;
    logic clr;

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] frame_q[$];

    ld_st_rg_serial_tx_if #(.WIDTH(WIDTH)) bus ();

    ld_st_rg_serial_tx #(
        .WIDTH (WIDTH),
        .CNT_W (2)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] modelOut();
        return (frame_q.size() != 0) ? frame_q[0] : SYM_IDLE;
    endfunction

    // Advance the model by one clock edge using the inputs sampled there.
    task automatic modelStep(input logic c, input logic l, input logic h,
                             input logic [WIDTH-1:0] d);
        if (c) begin
            frame_q.delete();
        end else if (frame_q.size() == 0) begin
            if (l) begin
                for (int i = 0; i < WIDTH; i++) frame_q.push_back({d[i], 3'b010});
`ifdef LD_ST_RG_PARITY_EN
                frame_q.push_back({^d, 3'b010});
`endif
                frame_q.push_back(SYM_DONE);
            end
        end else if (!(h && frame_q[0][1])) begin
            void'(frame_q.pop_front());
        end
    endtask

    // Drive one cycle of inputs, step the model at the edge, check 1ns later.
    task automatic applyStimulus(input logic c, input logic l, input logic h,
                                 input logic [WIDTH-1:0] d);
        clr       = c;
        bus.l_s   = l;
        bus.hold  = h;
        bus.sl_in = d;
        @(posedge clk);
        modelStep(c, l, h, d);
        #1;
        checkOutput("line", {28'd0, bus.sl_ser, bus.ready, bus.busy, bus.done},
                    {28'd0, modelOut()});
    endtask

    logic [WIDTH-1:0] w;

    initial begin
        clr       = 1'b1;
        bus.l_s   = 1'b0;
        bus.hold  = 1'b0;
        bus.sl_in = '0;

        // Reset state.
        applyStimulus(1, 0, 0, 4'h0);
        applyStimulus(1, 0, 0, 4'h0);
        checkOutput("rst_ready", bus.ready, 1);
        checkOutput("rst_ser", bus.sl_ser, 1);

        // Basic word 1011: bits 1,1,0,1, then done for one cycle, then ready.
        w = 4'b1011;
        applyStimulus(0, 1, 0, w);
        checkOutput("basic_bit", bus.sl_ser, w[0]);
        for (int i = 1; i < WIDTH; i++) begin
            applyStimulus(0, 0, 0, 4'h0);
            checkOutput("basic_bit", bus.sl_ser, w[i]);
        end
        for (int i = 0; i < PBITS; i++) begin
            applyStimulus(0, 0, 0, 4'h0);
            checkOutput("basic_par", bus.sl_ser, 1);
        end
        applyStimulus(0, 0, 0, 4'h0);
        checkOutput("basic_done", bus.done, 1);
        applyStimulus(0, 0, 0, 4'h0);
        checkOutput("basic_done_end", bus.done, 0);
        checkOutput("basic_ready", bus.ready, 1);

        // Reset mid-word: word is dropped, no done pulse afterwards.
        applyStimulus(0, 1, 0, 4'hF);
        applyStimulus(0, 0, 0, 4'hF);
        applyStimulus(1, 0, 0, 4'hF);
        applyStimulus(1, 0, 0, 4'hF);
        checkOutput("midrst_ready", bus.ready, 1);
        checkOutput("midrst_busy", bus.busy, 0);
        checkOutput("midrst_ser", bus.sl_ser, 1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, 4'hF);
            checkOutput("midrst_nodone", bus.done, 0);
        end

        // Hold for 3 cycles after bit1 of 0110: line stays 1 for 4 cycles.
        applyStimulus(0, 1, 0, 4'b0110);
        applyStimulus(0, 0, 0, 4'h0);
        checkOutput("hold_bit1", bus.sl_ser, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 4'h0);
            checkOutput("hold_frozen", bus.sl_ser, 1);
            checkOutput("hold_busy", bus.busy, 1);
        end
        applyStimulus(0, 0, 0, 4'h0);
        checkOutput("hold_bit2", bus.sl_ser, 1);
        applyStimulus(0, 0, 0, 4'h0);
        checkOutput("hold_bit3", bus.sl_ser, 0);
        repeat (4) applyStimulus(0, 0, 0, 4'h0);

        // Continuous strobe with toggling data: only ready cycles capture.
        for (int i = 0; i < 30; i++) applyStimulus(0, 1, 0, (i % 2) ? 4'hA : 4'h5);
        repeat (WIDTH + 2 + PBITS) applyStimulus(0, 0, 0, 4'h0);

        // Back-to-back: load on the first ready cycle after done.
        applyStimulus(0, 1, 0, 4'b1100);
        repeat (WIDTH + 1 + PBITS) applyStimulus(0, 0, 0, 4'h0);
        checkOutput("b2b_ready", bus.ready, 1);
        w = 4'b0101;
        applyStimulus(0, 1, 0, w);
        checkOutput("b2b_bit0", bus.sl_ser, w[0]);
        checkOutput("b2b_busy", bus.busy, 1);
        repeat (WIDTH + 2 + PBITS) applyStimulus(0, 0, 0, 4'h0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0),
                          $urandom_range(0, 1) == 1,
                          ($urandom_range(0, 3) == 0),
                          4'($urandom()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
